// File: rtl/csr_file.sv
// Machine-mode CSR file (mstatus/mtvec/mepc/mcause) with trap/mret handling and PC redirect.
// Response registered one cycle after accept; held in RESP until resp_ready, no new accept meanwhile.
module csr_file #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_op,
    input  logic [11:0]     cmd_addr,
    input  logic [XLEN-1:0] cmd_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_illegal,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_cause,
    input  logic            mret_valid,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] mstatus,
    output logic [XLEN-1:0] mtvec,
    output logic [XLEN-1:0] mepc,
    output logic [XLEN-1:0] mcause
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

    localparam logic [XLEN-1:0] MSTATUS_MPP   = XLEN'(32'h0000_1800);
    localparam logic [XLEN-1:0] MSTATUS_WMASK = XLEN'(32'h0000_0088);
    localparam logic [XLEN-1:0] ALIGN_MASK    = ~XLEN'(32'h3);

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    state_t state, state_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    logic            accept;
    logic            sel_mstatus, sel_mtvec, sel_mepc, sel_mcause, illegal;
    logic [XLEN-1:0] old_val, new_val;
    logic            op_writes, wr_en;
    logic [XLEN-1:0] mstatus_trap, mstatus_mret;

    always_comb begin
        accept      = cmd_valid && cmd_ready;
        sel_mstatus = (cmd_addr == ADDR_MSTATUS);
        sel_mtvec   = (cmd_addr == ADDR_MTVEC);
        sel_mepc    = (cmd_addr == ADDR_MEPC);
        sel_mcause  = (cmd_addr == ADDR_MCAUSE);
        illegal     = !(sel_mstatus || sel_mtvec || sel_mepc || sel_mcause);

        old_val = '0;
        if (sel_mstatus) old_val = mstatus;
        if (sel_mtvec)   old_val = mtvec;
        if (sel_mepc)    old_val = mepc;
        if (sel_mcause)  old_val = mcause;

        new_val   = old_val;
        op_writes = 1'b0;
        case (cmd_op)
            2'b01: begin new_val = cmd_wdata;            op_writes = 1'b1;             end
            2'b10: begin new_val = old_val | cmd_wdata;  op_writes = (cmd_wdata != '0); end
            2'b11: begin new_val = old_val & ~cmd_wdata; op_writes = (cmd_wdata != '0); end
            default: op_writes = 1'b0;
        endcase
        wr_en = accept && op_writes && !illegal;

        // MPIE <- MIE, MIE <- 0 on trap; MIE <- MPIE, MPIE <- 1 on mret
        mstatus_trap    = MSTATUS_MPP;
        mstatus_trap[7] = mstatus[3];
        mstatus_mret    = MSTATUS_MPP;
        mstatus_mret[7] = 1'b1;
        mstatus_mret[3] = mstatus[7];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mstatus <= MSTATUS_MPP;
            mtvec   <= '0;
            mepc    <= '0;
            mcause  <= '0;
        end else begin
            // Trap/mret own the CSRs they touch; mtvec writes are never blocked.
            if (trap_valid) begin
                mstatus <= mstatus_trap;
                mepc    <= trap_pc & ALIGN_MASK;
                mcause  <= trap_cause;
            end else begin
                if (mret_valid)
                    mstatus <= mstatus_mret;
                else if (wr_en && sel_mstatus)
                    mstatus <= (new_val & MSTATUS_WMASK) | MSTATUS_MPP;
                if (wr_en && sel_mepc)   mepc   <= new_val & ALIGN_MASK;
                if (wr_en && sel_mcause) mcause <= new_val;
            end
            if (wr_en && sel_mtvec) mtvec <= new_val & ALIGN_MASK;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_rdata   <= '0;
            resp_illegal <= 1'b0;
        end else if (accept) begin
            resp_rdata   <= old_val;
            resp_illegal <= illegal;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= trap_valid || mret_valid;
            if (trap_valid)      redirect_pc <= mtvec;
            else if (mret_valid) redirect_pc <= mepc;
        end
    end

endmodule

// File: tb/tb_csr_file.sv
// Directed self-checking bench for csr_file; expected values are hand-computed constants.
module tb_csr_file;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [11:0] cmd_addr = 12'h000;
    logic [31:0] cmd_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_illegal;
    logic        trap_valid = 1'b0;
    logic [31:0] trap_pc = 32'h0;
    logic [31:0] trap_cause = 32'h0;
    logic        mret_valid = 1'b0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] mstatus, mtvec, mepc, mcause;

    int vectors = 0;
    int miscompares = 0;

    csr_file #(.XLEN(32)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_illegal(resp_illegal),
        .trap_valid(trap_valid), .trap_pc(trap_pc), .trap_cause(trap_cause),
        .mret_valid(mret_valid),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mstatus(mstatus), .mtvec(mtvec), .mepc(mepc), .mcause(mcause)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Presents a command and returns #1 after the accept edge (DUT in RESP).
    task automatic do_cmd(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wdata);
        int n;
        n = 0;
        while (!cmd_ready && n < 20) begin
            step();
            n++;
        end
        vectors++;
        if (!cmd_ready) begin
            miscompares++;
            $display("FAIL cmd_ready_timeout: cmd_ready=%b required 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        resp_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        vectors++; if (mstatus !== 32'h0000_1800) begin miscompares++; $display("FAIL reset_mstatus: got %h required 00001800", mstatus); end
        vectors++; if (mtvec !== 32'h0) begin miscompares++; $display("FAIL reset_mtvec: got %h required 0", mtvec); end
        vectors++; if (mepc !== 32'h0) begin miscompares++; $display("FAIL reset_mepc: got %h required 0", mepc); end
        vectors++; if (mcause !== 32'h0) begin miscompares++; $display("FAIL reset_mcause: got %h required 0", mcause); end
        vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready); end
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_resp_valid: got %b required 0", resp_valid); end
        vectors++; if (redirect_valid !== 1'b0) begin miscompares++; $display("FAIL reset_redirect_valid: got %b required 0", redirect_valid); end
        vectors++; if (resp_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_resp_rdata: got %h required 0", resp_rdata); end
    endtask

    task automatic test_rw_mtvec();
        do_cmd(2'b01, 12'h305, 32'h8000_0103);
        vectors++; if (resp_valid !== 1'b1) begin miscompares++; $display("FAIL rw_resp_valid: got %b required 1", resp_valid); end
        vectors++; if (resp_rdata !== 32'h0) begin miscompares++; $display("FAIL rw_resp_rdata: got %h required 0", resp_rdata); end
        vectors++; if (resp_illegal !== 1'b0) begin miscompares++; $display("FAIL rw_resp_illegal: got %b required 0", resp_illegal); end
        vectors++; if (mtvec !== 32'h8000_0100) begin miscompares++; $display("FAIL rw_mtvec: got %h required 80000100", mtvec); end
        vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL rw_cmd_ready_in_resp: got %b required 0", cmd_ready); end
        step();
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL rw_resp_done: got %b required 0", resp_valid); end
        vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rw_back_idle: got %b required 1", cmd_ready); end
        do_cmd(2'b00, 12'h305, 32'hFFFF_FFFF);
        vectors++; if (resp_rdata !== 32'h8000_0100) begin miscompares++; $display("FAIL read_mtvec: got %h required 80000100", resp_rdata); end
        vectors++; if (mtvec !== 32'h8000_0100) begin miscompares++; $display("FAIL read_no_write: got %h required 80000100", mtvec); end
        step();
    endtask

    task automatic test_trap();
        do_cmd(2'b10, 12'h300, 32'h8);
        vectors++; if (resp_rdata !== 32'h0000_1800) begin miscompares++; $display("FAIL rs_rdata: got %h required 00001800", resp_rdata); end
        vectors++; if (mstatus !== 32'h0000_1808) begin miscompares++; $display("FAIL rs_mstatus: got %h required 00001808", mstatus); end
        step();
        trap_valid = 1'b1;
        trap_pc    = 32'h8000_0046;
        trap_cause = 32'd11;
        step();
        trap_valid = 1'b0;
        vectors++; if (mstatus !== 32'h0000_1880) begin miscompares++; $display("FAIL trap_mstatus: got %h required 00001880", mstatus); end
        vectors++; if (mepc !== 32'h8000_0044) begin miscompares++; $display("FAIL trap_mepc: got %h required 80000044", mepc); end
        vectors++; if (mcause !== 32'd11) begin miscompares++; $display("FAIL trap_mcause: got %h required 0000000b", mcause); end
        vectors++; if (redirect_valid !== 1'b1) begin miscompares++; $display("FAIL trap_redirect_valid: got %b required 1", redirect_valid); end
        vectors++; if (redirect_pc !== 32'h8000_0100) begin miscompares++; $display("FAIL trap_redirect_pc: got %h required 80000100", redirect_pc); end
        step();
        vectors++; if (redirect_valid !== 1'b0) begin miscompares++; $display("FAIL trap_redirect_pulse: got %b required 0", redirect_valid); end
    endtask

    task automatic test_mret();
        mret_valid = 1'b1;
        step();
        mret_valid = 1'b0;
        vectors++; if (mstatus !== 32'h0000_1888) begin miscompares++; $display("FAIL mret_mstatus: got %h required 00001888", mstatus); end
        vectors++; if (redirect_valid !== 1'b1) begin miscompares++; $display("FAIL mret_redirect_valid: got %b required 1", redirect_valid); end
        vectors++; if (redirect_pc !== 32'h8000_0044) begin miscompares++; $display("FAIL mret_redirect_pc: got %h required 80000044", redirect_pc); end
        step();
        vectors++; if (redirect_valid !== 1'b0) begin miscompares++; $display("FAIL mret_redirect_pulse: got %b required 0", redirect_valid); end
    endtask

    task automatic test_backpressure();
        resp_ready = 1'b0;
        do_cmd(2'b11, 12'h342, 32'h3);
        for (int i = 0; i < 5; i++) begin
            vectors++; if (resp_valid !== 1'b1) begin miscompares++; $display("FAIL bp_resp_valid[%0d]: got %b required 1", i, resp_valid); end
            vectors++; if (resp_rdata !== 32'd11) begin miscompares++; $display("FAIL bp_resp_rdata[%0d]: got %h required 0000000b", i, resp_rdata); end
            vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL bp_cmd_ready[%0d]: got %b required 0", i, cmd_ready); end
            vectors++; if (mcause !== 32'd8) begin miscompares++; $display("FAIL bp_mcause[%0d]: got %h required 00000008", i, mcause); end
            // A command offered while stalled must not be taken.
            cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 12'h342; cmd_wdata = 32'hDEAD_BEEF;
            step();
        end
        cmd_valid = 1'b0;
        vectors++; if (mcause !== 32'd8) begin miscompares++; $display("FAIL bp_no_accept: got %h required 00000008", mcause); end
        resp_ready = 1'b1;
        step();
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release_valid: got %b required 0", resp_valid); end
        vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready: got %b required 1", cmd_ready); end
    endtask

    task automatic test_illegal();
        do_cmd(2'b00, 12'h344, 32'h0);
        vectors++; if (resp_illegal !== 1'b1) begin miscompares++; $display("FAIL illegal_flag: got %b required 1", resp_illegal); end
        vectors++; if (resp_rdata !== 32'h0) begin miscompares++; $display("FAIL illegal_rdata: got %h required 0", resp_rdata); end
        step();
        do_cmd(2'b01, 12'h344, 32'hFFFF_FFFF);
        vectors++; if (mstatus !== 32'h0000_1888) begin miscompares++; $display("FAIL illegal_no_state: got %h required 00001888", mstatus); end
        step();
    endtask

    task automatic test_coincident();
        cmd_valid  = 1'b1; cmd_op = 2'b01; cmd_addr = 12'h341; cmd_wdata = 32'h1234;
        trap_valid = 1'b1; trap_pc = 32'h8000_0200; trap_cause = 32'd2;
        step();
        cmd_valid = 1'b0; trap_valid = 1'b0;
        vectors++; if (resp_valid !== 1'b1) begin miscompares++; $display("FAIL coin_resp_valid: got %b required 1", resp_valid); end
        vectors++; if (resp_rdata !== 32'h8000_0044) begin miscompares++; $display("FAIL coin_resp_rdata: got %h required 80000044", resp_rdata); end
        vectors++; if (mepc !== 32'h8000_0200) begin miscompares++; $display("FAIL coin_mepc: got %h required 80000200", mepc); end
        vectors++; if (mcause !== 32'd2) begin miscompares++; $display("FAIL coin_mcause: got %h required 00000002", mcause); end
        vectors++; if (mstatus !== 32'h0000_1880) begin miscompares++; $display("FAIL coin_mstatus: got %h required 00001880", mstatus); end
        step();
        // mtvec write alongside mret still lands; mret uses the pre-edge mepc.
        cmd_valid  = 1'b1; cmd_op = 2'b01; cmd_addr = 12'h305; cmd_wdata = 32'h0000_0202;
        mret_valid = 1'b1;
        step();
        cmd_valid = 1'b0; mret_valid = 1'b0;
        vectors++; if (mtvec !== 32'h0000_0200) begin miscompares++; $display("FAIL coin_mtvec: got %h required 00000200", mtvec); end
        vectors++; if (redirect_pc !== 32'h8000_0200) begin miscompares++; $display("FAIL coin_mret_pc: got %h required 80000200", redirect_pc); end
        vectors++; if (mstatus !== 32'h0000_1888) begin miscompares++; $display("FAIL coin_mret_mstatus: got %h required 00001888", mstatus); end
        step();
    endtask

    task automatic test_reset_in_resp();
        resp_ready = 1'b0;
        do_cmd(2'b01, 12'h342, 32'h55);
        vectors++; if (mcause !== 32'h55) begin miscompares++; $display("FAIL rr_mcause_pre: got %h required 00000055", mcause); end
        #2;
        reset = 1'b1;
        #1;
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL rr_resp_valid: got %b required 0", resp_valid); end
        vectors++; if (mcause !== 32'h0) begin miscompares++; $display("FAIL rr_mcause: got %h required 0", mcause); end
        vectors++; if (mtvec !== 32'h0) begin miscompares++; $display("FAIL rr_mtvec: got %h required 0", mtvec); end
        step();
        reset = 1'b0;
        resp_ready = 1'b1;
        step();
        vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rr_cmd_ready: got %b required 1", cmd_ready); end
        vectors++; if (mstatus !== 32'h0000_1800) begin miscompares++; $display("FAIL rr_mstatus: got %h required 00001800", mstatus); end
    endtask

    initial begin
        test_reset();
        test_rw_mtvec();
        test_trap();
        test_mret();
        test_backpressure();
        test_illegal();
        test_coincident();
        test_reset_in_resp();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Machine-mode CSR register file for the NPC core.
- Owns mstatus, mtvec, mepc and mcause, and services CSR read-modify-write commands from the execute stage over a valid/ready handshake.
- Performs trap entry (ecall/exceptions) and mret state updates, and issues PC redirects.
- Exports the live register values as outputs so the simulation CSR probe and difftest can read them.

Parameters:
- XLEN, 32, data width of every CSR and of the PC.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  CSR command present.
- cmd_ready  output  1  block can accept a command.
- cmd_op  input  2  00 read-only, 01 CSRRW, 10 CSRRS, 11 CSRRC.
- cmd_addr  input  12  CSR address.
- cmd_wdata  input  XLEN  rs1 or zimm operand.
- resp_valid  output  1  response holds the old CSR value.
- resp_ready  input  1  consumer accepts the response.
- resp_rdata  output  XLEN  CSR value before the write.
- resp_illegal  output  1  address not implemented.
- trap_valid  input  1  one-cycle trap-entry pulse.
- trap_pc  input  XLEN  PC of the faulting instruction.
- trap_cause  input  XLEN  mcause value to record.
- mret_valid  input  1  one-cycle mret pulse.
- redirect_valid  output  1  one-cycle redirect pulse.
- redirect_pc  output  XLEN  redirect target.
- mstatus, mtvec, mepc, mcause  output  XLEN each  live register values.

Behaviour:
- Reset (asynchronous, effective immediately on assertion):
  - mstatus = 0x0000_1800 (MPP=11); mtvec = mepc = mcause = 0.
  - FSM = IDLE; resp_valid = 0, resp_rdata = 0, resp_illegal = 0.
  - redirect_valid = 0, redirect_pc = 0.
- Reset mid-operation: any pending response is discarded, and no CSR write from the interrupted command survives.
- FSM states:
  - IDLE: cmd_ready = 1. The handshake completes when cmd_valid && cmd_ready; go to RESP.
  - RESP: cmd_ready = 0, resp_valid = 1, and resp_rdata/resp_illegal are held stable. On resp_valid && resp_ready, return to IDLE. A new command is never accepted in the same cycle the response completes.
- Command latency: the response appears the cycle after the accept.
  - resp_rdata is the CSR value before the write.
  - The CSR write commits on the accept edge, so the probe outputs show the new value in RESP.
- Addresses:
  - Implemented: 0x300 mstatus, 0x305 mtvec, 0x341 mepc, 0x342 mcause.
  - Any other address: resp_rdata = 0, resp_illegal = 1, no state change.
- Write value:
  - RW: new = wdata.
  - RS: new = old | wdata.
  - RC: new = old & ~wdata.
  - op 00: no write.
  - RS/RC with wdata == 0: no write.
- Field masks on every CSR write:
  - mstatus: only bit 3 (MIE) and bit 7 (MPIE) are writable; MPP[12:11] always reads 11; all other bits read 0.
  - mtvec: bits [1:0] forced to 00 (direct mode only).
  - mepc: bits [1:0] forced to 00.
  - mcause: fully writable.
- Trap entry (trap_valid, any FSM state), on the next edge:
  - mepc = trap_pc with [1:0] cleared; mcause = trap_cause.
  - MPIE = MIE, MIE = 0, MPP = 11.
  - redirect_valid pulses for one cycle with redirect_pc = mtvec (value before this edge).
- mret (mret_valid), on the next edge:
  - MIE = MPIE, MPIE = 1, MPP = 11.
  - redirect_valid pulses with redirect_pc = mepc.
- Same-cycle event priority: trap > mret > CSR command write.
  - If trap and mret coincide, mret is ignored.
  - If a command is accepted in the same cycle as a trap or mret, the handshake still completes and resp_rdata returns the pre-edge value, but the command's write to any CSR also touched by the trap/mret is dropped.
  - A command write to mtvec is never blocked.
- redirect_valid is a one-cycle pulse; it deasserts the following cycle unless a new trap or mret arrives.
- Probe outputs are direct register outputs with no combinational path from the inputs.

Test Plan:
- Reset, then hold resp_ready=1: mstatus=0x1800, mtvec/mepc/mcause=0, cmd_ready=1, resp_valid=0, redirect_valid=0.
- CSRRW 0x305 with wdata 0x8000_0103: resp_rdata=0 one cycle later; mtvec=0x8000_0100. A follow-up op 00 read of 0x305 returns 0x8000_0100.
- CSRRS 0x300 with wdata 0x8, then trap_valid with trap_pc 0x8000_0046, cause 11:
  - mstatus goes 0x1808 -> 0x1880; mepc=0x8000_0044; mcause=11.
  - redirect_pc=0x8000_0100 pulses for one cycle.
- mret after the previous step: mstatus=0x1888; redirect_pc=0x8000_0044.
- Hold resp_ready=0 for 5 cycles after a CSRRC 0x342 with wdata 0x3 (mcause=11): resp_valid and resp_rdata=11 stay stable, cmd_ready=0, mcause=8. Raising resp_ready returns the FSM to IDLE.
- Read of 0x344, plus a trap coinciding with CSRRW 0x341 wdata 0x1234, plus reset asserted in RESP:
  - 0x344 read gives resp_illegal=1, resp_rdata=0.
  - The coincident case leaves mepc = trap_pc.
  - Reset in RESP clears resp_valid immediately.
